// File: rtl/fp_result_packer.sv
// fp_result_packer: packs adder results into IEEE-754 words, queued in a 2-entry FIFO.
// Optional sticky exception flags are enabled by defining PACKER_FLAGS_EN.
module fp_result_packer (
  input  logic        CLK,
  input  logic        rst,
  input  logic        add_done,
  input  logic        s_R,
  input  logic [8:0]  exp_R,
  input  logic [23:0] man_R,
  input  logic        res_ready,
`ifdef PACKER_FLAGS_EN
  input  logic        flag_clr,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_missed,
`endif
  output logic [31:0] res_data,
  output logic        res_valid,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CLASSIFY, PUSH} state_t;
  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        cap_s_q, cap_s_d;
  logic [8:0]  cap_exp_q, cap_exp_d;
  logic [23:0] cap_man_q, cap_man_d;
  logic [31:0] pack_q, pack_d, word;
  logic [31:0] mem_q [2];
  logic [31:0] mem_d [2];
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [1:0]  count_q, count_d;
  logic        capture, pop, push, is_ovf, is_unf;
  always_comb begin
    capture   = add_done && !done_q;
    pop       = res_valid && res_ready;
    push      = (state_q == PUSH) && (count_q != 2'd2 || pop);
    done_d    = add_done;
    state_d   = state_q == IDLE ? (capture ? CLASSIFY : IDLE)
              : state_q == CLASSIFY ? PUSH : (push ? IDLE : PUSH);
    cap_s_d   = (state_q == IDLE && capture) ? s_R : cap_s_q;
    cap_exp_d = (state_q == IDLE && capture) ? exp_R : cap_exp_q;
    cap_man_d = (state_q == IDLE && capture) ? man_R : cap_man_q;
    is_ovf    = cap_man_q != 24'd0 && cap_exp_q >= 9'd255;
    is_unf    = cap_man_q != 24'd0 && cap_exp_q == 9'd0;
    word      = (cap_man_q == 24'd0 || is_unf) ? {cap_s_q, 31'b0}
              : is_ovf ? {cap_s_q, 8'hFF, 23'b0}
              : {cap_s_q, cap_exp_q[7:0], cap_man_q[22:0]};
    pack_d    = state_q == CLASSIFY ? word : pack_q;
    mem_d     = mem_q;
    if (push) mem_d[wr_q] = pack_q;
    wr_d      = wr_q ^ push;
    rd_d      = rd_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b1;
      cap_s_q   <= 1'b0;
      cap_exp_q <= '0;
      cap_man_q <= '0;
      pack_q    <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cap_s_q   <= cap_s_d;
      cap_exp_q <= cap_exp_d;
      cap_man_q <= cap_man_d;
      pack_q    <= pack_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
    end
  end
  assign res_valid = count_q != 2'd0;
  assign res_data  = res_valid ? mem_q[rd_q] : '0;
  assign busy      = state_q != IDLE;
`ifdef PACKER_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d, missed_q, missed_d;
  // a set in the same cycle as a clear wins
  always_comb begin
    ovf_d    = (ovf_q && !flag_clr) || (state_q == CLASSIFY && is_ovf);
    unf_d    = (unf_q && !flag_clr) || (state_q == CLASSIFY && is_unf);
    missed_d = (missed_q && !flag_clr) || (capture && state_q != IDLE);
  end
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      missed_q <= missed_d;
    end
  end
  assign flag_ovf    = ovf_q;
  assign flag_unf    = unf_q;
  assign flag_missed = missed_q;
`endif
endmodule

// File: doc/fp_result_packer.md
FP_RESULT_PACKER -- requirements
Module: fp_result_packer

Interface
REQ-001 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-002 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 add_done  input  1  adder-controller done level; 1 while adder idle, 0 while an addition runs.
REQ-004 s_R  input  1  result sign from adder datapath.
REQ-005 exp_R  input  9  result exponent from adder datapath; bit 8 set means exponent overflowed.
REQ-006 man_R  input  24  result mantissa; bit 23 is the hidden bit.
REQ-007 res_data  output  32  packed IEEE-754 single-precision word at FIFO head.
REQ-008 res_valid  output  1  res_data holds an unread result.
REQ-009 res_ready  input  1  consumer accepts res_data this cycle.
REQ-010 busy  output  1  packer is not in IDLE.
REQ-011 flag_ovf, flag_unf, flag_missed  output  1 each  sticky exception flags; present only under PACKER_FLAGS_EN.
REQ-012 flag_clr  input  1  synchronous clear of all sticky flags; present only under PACKER_FLAGS_EN.

Function
REQ-013 Capture event SHALL be a rising edge of add_done: add_done==1 while registered done_q==0.
REQ-014 FSM SHALL have exactly three states: IDLE, CLASSIFY, PUSH.
REQ-015 IDLE: on a capture event, load s_R, exp_R and man_R into capture registers and go to CLASSIFY; otherwise stay in IDLE.
REQ-016 CLASSIFY: form the packed word into a register and go to PUSH unconditionally.
REQ-017 Packing SHALL use the first matching rule: man_R==0 -> {s,31'b0}; exp_R>=255 -> {s,8'hFF,23'b0}; exp_R==0 -> {s,31'b0} (flush to zero); otherwise {s,exp_R[7:0],man_R[22:0]}.
REQ-018 PUSH: write the packed word into the FIFO when it is not full, or when it is full and a pop occurs in the same cycle, then go to IDLE; otherwise stay in PUSH.
REQ-019 Output FIFO SHALL be 2 entries deep; res_valid=(count!=0); res_data=head entry.
REQ-020 A pop SHALL occur when res_valid && res_ready; a simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-021 res_data SHALL be held stable while res_valid && !res_ready.
REQ-022 Latency: a capture event in cycle N gives res_valid=1 in cycle N+3 when the FIFO is empty and there is no stall.
REQ-023 busy SHALL be 1 in CLASSIFY and PUSH and 0 in IDLE.
REQ-024 A capture event outside IDLE SHALL be dropped; no FIFO write SHALL result from it.

Reset
REQ-025 While rst==0: FSM=IDLE, done_q=1, FIFO count=0, read and write pointers=0, res_valid=0, busy=0, res_data=0, all flags=0.
REQ-026 done_q reset value 1 SHALL suppress a spurious capture from the adder's idle-high done after reset.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight capture and all FIFO contents.

Configuration
REQ-028 Macro PACKER_FLAGS_EN defined: flag_ovf SHALL set on an overflow pack, flag_unf on a flush-to-zero pack with man_R!=0, and flag_missed on a dropped capture (REQ-024).
REQ-029 With PACKER_FLAGS_EN defined, all flags SHALL hold until flag_clr==1; a set and a clear in the same cycle SHALL leave the flag set.
REQ-030 Macro PACKER_FLAGS_EN undefined: the flag and flag_clr ports and their logic SHALL be absent, with no other behavioural change.

Verification
REQ-031 Reset release with add_done=1, no edge -> res_valid stays 0 for 10 cycles.
REQ-032 Edge with s=0, exp=9'h7F, man=24'hC00000, res_ready=1 -> res_data=32'h3FC00000 and res_valid rise exactly 3 cycles after the edge.
REQ-033 Edge with exp=9'h100, s=1 -> res_data=32'hFF800000 and flag_ovf=1; edge with man=0, s=1 -> 32'h80000000.
REQ-034 Three edges 5 cycles apart with res_ready=0 -> two entries queued, busy held in PUSH; res_ready=1 -> three words popped in order.
REQ-035 Edge issued while in CLASSIFY -> no extra FIFO entry and flag_missed=1; flag_clr=1 -> flag_missed=0 the next cycle.
REQ-036 rst=0 pulse while in PUSH with FIFO full -> res_valid=0 and busy=0 immediately, no word emitted after release.
